// File: rtl/isp1761_access_sequencer_pkg.sv
// Shared types and default bus timing for the ISP1761 access sequencer.
// Timing values are counted in csi_clk cycles.
package isp1761_pkg;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam int unsigned DEF_T_SETUP   = 1;
    localparam int unsigned DEF_T_STROBE  = 4;
    localparam int unsigned DEF_T_HOLD    = 1;
    localparam int unsigned DEF_T_RECOVER = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DONE    = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

endpackage

// File: rtl/isp1761_access_sequencer_if.sv
// Bundles the CPU-side slave bus and the downstream chip bus of the sequencer.
// master = CPU, slave = sequencer, device = ISP1761-side memory model.
interface isp1761_access_sequencer_if;

    logic [17:0] avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;

    logic        coe_cs_n;
    logic [17:0] coe_address;
    logic        coe_read_n;
    logic        coe_write_n;
    logic [31:0] coe_writedata;
    logic [31:0] coe_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, coe_readdata,
        output avs_readdata, avs_waitrequest,
        output coe_cs_n, coe_address, coe_read_n, coe_write_n, coe_writedata
    );

    modport device (
        input  coe_cs_n, coe_address, coe_read_n, coe_write_n, coe_writedata,
        output coe_readdata
    );

endinterface

// File: rtl/isp1761_access_sequencer.sv
// Turns single Avalon-style read/write requests into timed ISP1761 bus cycles
// (setup / strobe / hold / recover), every output driven from a register.
module isp1761_access_sequencer
    import isp1761_pkg::*;
#(
    parameter int unsigned T_SETUP   = DEF_T_SETUP,
    parameter int unsigned T_STROBE  = DEF_T_STROBE,
    parameter int unsigned T_HOLD    = DEF_T_HOLD,
    parameter int unsigned T_RECOVER = DEF_T_RECOVER
) (
    input  logic              csi_clk,
    input  logic              rsi_rst_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic              coe_cs_n,
    output logic [ADDR_W-1:0] coe_address,
    output logic              coe_read_n,
    output logic              coe_write_n,
    output logic [DATA_W-1:0] coe_writedata,
    input  logic [DATA_W-1:0] coe_readdata
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               r_is_write;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_readdata;
    logic               r_cs_n;
    logic               r_read_n;
    logic               r_write_n;
    logic               r_wait;

    logic               w_accept;
    logic               w_dir_nxt;
    logic               w_cs_n_nxt;
    logic               w_read_n_nxt;
    logic               w_write_n_nxt;
    logic               w_wait_nxt;
    logic               w_capture;

    // Counter preload on entry to a timed state; it counts down to zero.
    function automatic logic [CNT_W-1:0] load_count(input state_t s);
        case (s)
            ST_SETUP:   load_count = CNT_W'(T_SETUP)   - 1'b1;
            ST_STROBE:  load_count = CNT_W'(T_STROBE)  - 1'b1;
            ST_HOLD:    load_count = CNT_W'(T_HOLD)    - 1'b1;
            ST_RECOVER: load_count = CNT_W'(T_RECOVER) - 1'b1;
            default:    load_count = '0;
        endcase
    endfunction

    // A request is only ever looked at in IDLE; both strobes high means write.
    assign w_accept  = (r_state == ST_IDLE) && (avs_read || avs_write);
    assign w_dir_nxt = w_accept ? avs_write : r_is_write;
    assign w_capture = (r_state == ST_STROBE) && (r_cnt == '0) && !r_is_write;

    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_state_nxt = (T_SETUP != 0) ? ST_SETUP : ST_STROBE;
            end
            ST_SETUP: begin
                if (r_cnt == '0) w_state_nxt = ST_STROBE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            ST_STROBE: begin
                if (r_cnt == '0) w_state_nxt = (T_HOLD != 0) ? ST_HOLD : ST_DONE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            ST_HOLD: begin
                if (r_cnt == '0) w_state_nxt = ST_DONE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            ST_DONE: begin
                w_state_nxt = (T_RECOVER != 0) ? ST_RECOVER : ST_IDLE;
            end
            ST_RECOVER: begin
                if (r_cnt == '0) w_state_nxt = ST_IDLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_state_nxt != r_state)
            w_cnt_nxt = load_count(w_state_nxt);
    end

    // Outputs are decoded from the next state so the registers line up with it.
    always_comb begin
        w_cs_n_nxt    = 1'b1;
        w_read_n_nxt  = 1'b1;
        w_write_n_nxt = 1'b1;
        w_wait_nxt    = 1'b1;
        case (w_state_nxt)
            ST_SETUP, ST_HOLD: w_cs_n_nxt = 1'b0;
            ST_STROBE: begin
                w_cs_n_nxt = 1'b0;
                if (w_dir_nxt) w_write_n_nxt = 1'b0;
                else           w_read_n_nxt  = 1'b0;
            end
            ST_DONE: w_wait_nxt = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_readdata <= '0;
            r_cs_n     <= 1'b1;
            r_read_n   <= 1'b1;
            r_write_n  <= 1'b1;
            r_wait     <= 1'b1;
        end else begin
            if (w_accept) begin
                r_is_write <= avs_write;
                r_addr     <= avs_address;
                r_wdata    <= avs_writedata;
            end
            if (w_capture)
                r_readdata <= coe_readdata;
            r_cs_n    <= w_cs_n_nxt;
            r_read_n  <= w_read_n_nxt;
            r_write_n <= w_write_n_nxt;
            r_wait    <= w_wait_nxt;
        end
    end

    assign avs_readdata    = r_readdata;
    assign avs_waitrequest = r_wait;
    assign coe_cs_n        = r_cs_n;
    assign coe_address     = r_addr;
    assign coe_read_n      = r_read_n;
    assign coe_write_n     = r_write_n;
    assign coe_writedata   = r_wdata;

endmodule

// File: tb/tb_isp1761_access_sequencer.sv
// Bench for the ISP1761 access sequencer: a default-timing instance (A) and a
// minimum-timing instance (B), checked against cycle counts derived from timing.
module tb_isp1761_access_sequencer;

    localparam int A_TS = 1, A_TST = 4, A_TH = 1, A_TR = 2;
    localparam int B_TS = 0, B_TST = 1, B_TH = 0, B_TR = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    bit          sel = 1'b0;
    logic        rq_read = 1'b0, rq_write = 1'b0;
    logic [17:0] rq_addr = '0;
    logic [31:0] rq_wdata = '0;
    logic [31:0] rd_val = '0;
    logic [31:0] last_rd [2];
    int          checks = 0, errors = 0;
    int          cnt_a = 0, cnt_b = 0;

    always #5 clk = ~clk;

    isp1761_access_sequencer_if ifa ();
    isp1761_access_sequencer_if ifb ();

    assign ifa.avs_read      = rq_read  & ~sel;
    assign ifa.avs_write     = rq_write & ~sel;
    assign ifa.avs_address   = rq_addr;
    assign ifa.avs_writedata = rq_wdata;
    assign ifb.avs_read      = rq_read  & sel;
    assign ifb.avs_write     = rq_write & sel;
    assign ifb.avs_address   = rq_addr;
    assign ifb.avs_writedata = rq_wdata;

    // Device model: the exact rd_val appears only in the last strobe cycle.
    always @(posedge clk) cnt_a <= (ifa.coe_read_n === 1'b0) ? cnt_a + 1 : 0;
    always @(posedge clk) cnt_b <= (ifb.coe_read_n === 1'b0) ? cnt_b + 1 : 0;
    assign ifa.coe_readdata = (ifa.coe_read_n === 1'b0) ? (rd_val ^ 32'(A_TST - 1 - cnt_a)) : ~rd_val;
    assign ifb.coe_readdata = (ifb.coe_read_n === 1'b0) ? (rd_val ^ 32'(B_TST - 1 - cnt_b)) : ~rd_val;

    isp1761_access_sequencer #(
        .T_SETUP(A_TS), .T_STROBE(A_TST), .T_HOLD(A_TH), .T_RECOVER(A_TR)
    ) dut_a (
        .csi_clk(clk), .rsi_rst_n(rst_n),
        .avs_address(ifa.avs_address), .avs_read(ifa.avs_read), .avs_write(ifa.avs_write),
        .avs_writedata(ifa.avs_writedata), .avs_readdata(ifa.avs_readdata),
        .avs_waitrequest(ifa.avs_waitrequest),
        .coe_cs_n(ifa.coe_cs_n), .coe_address(ifa.coe_address), .coe_read_n(ifa.coe_read_n),
        .coe_write_n(ifa.coe_write_n), .coe_writedata(ifa.coe_writedata),
        .coe_readdata(ifa.coe_readdata)
    );

    isp1761_access_sequencer #(
        .T_SETUP(B_TS), .T_STROBE(B_TST), .T_HOLD(B_TH), .T_RECOVER(B_TR)
    ) dut_b (
        .csi_clk(clk), .rsi_rst_n(rst_n),
        .avs_address(ifb.avs_address), .avs_read(ifb.avs_read), .avs_write(ifb.avs_write),
        .avs_writedata(ifb.avs_writedata), .avs_readdata(ifb.avs_readdata),
        .avs_waitrequest(ifb.avs_waitrequest),
        .coe_cs_n(ifb.coe_cs_n), .coe_address(ifb.coe_address), .coe_read_n(ifb.coe_read_n),
        .coe_write_n(ifb.coe_write_n), .coe_writedata(ifb.coe_writedata),
        .coe_readdata(ifb.coe_readdata)
    );

    logic        m_cs_n, m_read_n, m_write_n, m_wait;
    logic [17:0] m_addr;
    logic [31:0] m_wdata, m_readdata;
    assign m_cs_n     = sel ? ifb.coe_cs_n        : ifa.coe_cs_n;
    assign m_read_n   = sel ? ifb.coe_read_n      : ifa.coe_read_n;
    assign m_write_n  = sel ? ifb.coe_write_n     : ifa.coe_write_n;
    assign m_wait     = sel ? ifb.avs_waitrequest : ifa.avs_waitrequest;
    assign m_addr     = sel ? ifb.coe_address     : ifa.coe_address;
    assign m_wdata    = sel ? ifb.coe_writedata   : ifa.coe_writedata;
    assign m_readdata = sel ? ifb.avs_readdata    : ifa.avs_readdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe exclusivity and strobe-inside-chip-select, on both instances every cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("a_both_strobes", 32'(ifa.coe_read_n === 1'b0 && ifa.coe_write_n === 1'b0), 32'd0);
            check("a_strobe_no_cs", 32'((ifa.coe_read_n === 1'b0 || ifa.coe_write_n === 1'b0) && ifa.coe_cs_n !== 1'b0), 32'd0);
            check("b_both_strobes", 32'(ifb.coe_read_n === 1'b0 && ifb.coe_write_n === 1'b0), 32'd0);
            check("b_strobe_no_cs", 32'((ifb.coe_read_n === 1'b0 || ifb.coe_write_n === 1'b0) && ifb.coe_cs_n !== 1'b0), 32'd0);
        end
    end

    // mode 0: release after DONE; 1: release early and scramble inputs; 2: hold for back-to-back.
    task automatic run_access(input bit s, input bit rd, input bit wr, input logic [17:0] a,
                              input logic [31:0] d, input logic [31:0] rv, input int mode);
        int ts, tst, th, tr, lat, per;
        int done_cyc = -1, cs_cnt = 0, good_st = 0, bad_st = 0, pos_bad = 0, fall1 = -1, fall2 = -1;
        logic prev_cs = 1'b1;
        logic [31:0] rd_seen = '0;
        logic [31:0] exp_rd;
        ts  = s ? B_TS  : A_TS;
        tst = s ? B_TST : A_TST;
        th  = s ? B_TH  : A_TH;
        tr  = s ? B_TR  : A_TR;
        lat = 1 + ts + tst + th;
        per = 2 + ts + tst + th + tr;
        @(posedge clk); #1;
        sel = s; rd_val = rv;
        rq_read = rd; rq_write = wr; rq_addr = a; rq_wdata = d;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check("idle_cs_n", 32'(m_cs_n), 32'd1);
                check("idle_wait", 32'(m_wait), 32'd1);
            end
            if (prev_cs === 1'b1 && m_cs_n === 1'b0) begin
                if (fall1 < 0) fall1 = cyc;
                else if (fall2 < 0) fall2 = cyc;
            end
            prev_cs = m_cs_n;
            if (done_cyc < 0) begin
                if (m_cs_n === 1'b0) begin
                    cs_cnt++;
                    if (m_addr !== a || m_wdata !== d) pos_bad++;
                end
                if ((wr ? m_write_n : m_read_n) === 1'b0) good_st++;
                if ((wr ? m_read_n : m_write_n) === 1'b0) bad_st++;
                if (m_wait === 1'b0) begin
                    done_cyc = cyc;
                    rd_seen  = m_readdata;
                end
            end
            if (mode == 1 && cyc == 1) begin
                rq_read = 1'b0; rq_write = 1'b0;
                rq_addr = 18'($urandom); rq_wdata = $urandom;
            end
            if (mode != 2 && done_cyc >= 0) break;
            if (mode == 2 && fall2 >= 0) break;
        end
        rq_read = 1'b0; rq_write = 1'b0;
        exp_rd = wr ? last_rd[s] : rv;
        check("done_latency", 32'(done_cyc), 32'(lat));
        check("cs_low_cycles", 32'(cs_cnt), 32'(ts + tst + th));
        check("strobe_cycles", 32'(good_st), 32'(tst));
        check("wrong_strobe", 32'(bad_st), 32'd0);
        check("addr_data_stable", 32'(pos_bad), 32'd0);
        check("cs_first_fall", 32'(fall1), 32'd1);
        check("readdata", rd_seen, exp_rd);
        if (mode == 2) check("req_period", 32'(fall2 - fall1), 32'(per));
        if (!wr) last_rd[s] = rv;
        repeat (2 * per + 4) @(negedge clk);
    endtask

    initial begin
        int wait_lo, cs_lo;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_a_cs_n",    32'(ifa.coe_cs_n), 32'd1);
        check("rst_a_read_n",  32'(ifa.coe_read_n), 32'd1);
        check("rst_a_write_n", 32'(ifa.coe_write_n), 32'd1);
        check("rst_a_wait",    32'(ifa.avs_waitrequest), 32'd1);
        check("rst_a_addr",    32'(ifa.coe_address), 32'd0);
        check("rst_a_wdata",   ifa.coe_writedata, 32'd0);
        check("rst_a_rdata",   ifa.avs_readdata, 32'd0);
        check("rst_b_cs_n",    32'(ifb.coe_cs_n), 32'd1);
        check("rst_b_wait",    32'(ifb.avs_waitrequest), 32'd1);
        rst_n = 1'b1;

        run_access(1'b0, 1'b0, 1'b1, 18'h00304, 32'hDEADBEEF, 32'h0, 0);
        run_access(1'b0, 1'b1, 1'b0, 18'h0030C, 32'h0BADF00D, 32'h12345678, 0);
        run_access(1'b0, 1'b0, 1'b1, 18'h00100, 32'hA5A5_5A5A, 32'h0, 2);
        run_access(1'b1, 1'b1, 1'b0, 18'h00020, 32'h1111_2222, 32'hCAFEF00D, 0);
        run_access(1'b1, 1'b1, 1'b0, 18'h00024, 32'h3333_4444, 32'h0F0F_0F0F, 2);
        run_access(1'b0, 1'b1, 1'b1, 18'h00200, 32'h5555_AAAA, 32'hFFFF_0000, 0);
        run_access(1'b1, 1'b1, 1'b1, 18'h00204, 32'h6666_7777, 32'h0000_FFFF, 0);
        run_access(1'b0, 1'b1, 1'b0, 18'h3FFFC, 32'h8888_9999, 32'h7654_3210, 1);
        run_access(1'b1, 1'b0, 1'b1, 18'h00000, 32'hFFFF_FFFF, 32'h0, 1);

        // Reset pulse during the first strobe cycle of a default-timing write.
        @(posedge clk); #1;
        sel = 1'b0; rq_write = 1'b1; rq_addr = 18'h01234; rq_wdata = 32'hFEEDFACE;
        repeat (3) @(negedge clk);
        check("pre_rst_write_n", 32'(ifa.coe_write_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs_n",    32'(ifa.coe_cs_n), 32'd1);
        check("arst_write_n", 32'(ifa.coe_write_n), 32'd1);
        check("arst_read_n",  32'(ifa.coe_read_n), 32'd1);
        check("arst_wait",    32'(ifa.avs_waitrequest), 32'd1);
        check("arst_addr",    32'(ifa.coe_address), 32'd0);
        check("arst_wdata",   ifa.coe_writedata, 32'd0);
        rq_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        wait_lo = 0; cs_lo = 0;
        repeat (12) begin
            @(negedge clk);
            if (ifa.avs_waitrequest === 1'b0) wait_lo++;
            if (ifa.coe_cs_n === 1'b0) cs_lo++;
        end
        check("post_rst_no_done", 32'(wait_lo), 32'd0);
        check("post_rst_no_cs",   32'(cs_lo), 32'd0);
        run_access(1'b0, 1'b0, 1'b1, 18'h01234, 32'hFEEDFACE, 32'h0, 0);
        run_access(1'b0, 1'b1, 1'b0, 18'h01238, 32'h0, 32'h9ABC_DEF0, 0);

        for (int i = 0; i < 30; i++) begin
            bit s, r, w;
            int kind, mode;
            s    = 1'($urandom);
            kind = int'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 2));
            r    = (kind == 0) || (kind == 2);
            w    = (kind != 0);
            run_access(s, r, w, 18'($urandom), $urandom, $urandom, mode);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/isp1761_access_sequencer.md
ISP1761_ACCESS_SEQUENCER -- requirements
Module: isp1761_access_sequencer

Interface
REQ-001 Parameters, one per line: T_SETUP, 1, cycles cs_n low before strobe (0..15, 0 = state skipped).
REQ-002 T_STROBE, 4, cycles read_n/write_n low (1..15).
REQ-003 T_HOLD, 1, cycles cs_n low after strobe release (0..15, 0 = skipped).
REQ-004 T_RECOVER, 2, idle cycles, cs_n high, before next access (0..15, 0 = skipped).
REQ-005 Ports, one per line: csi_clk  in  1  sole clock; all logic on rising edge.
REQ-006 rsi_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 avs_address  in  18  CPU-side byte address.
REQ-008 avs_read  in  1  CPU read request, active-high.
REQ-009 avs_write  in  1  CPU write request, active-high.
REQ-010 avs_writedata  in  32  CPU write data.
REQ-011 avs_readdata  out  32  read data, valid while avs_waitrequest low after a read.
REQ-012 avs_waitrequest  out  1  high = access not complete.
REQ-013 coe_cs_n  out  1  downstream chip select, active-low.
REQ-014 coe_address  out  18  downstream address.
REQ-015 coe_read_n  out  1  downstream read strobe, active-low.
REQ-016 coe_write_n  out  1  downstream write strobe, active-low.
REQ-017 coe_writedata  out  32  downstream write data.
REQ-018 coe_readdata  in  32  downstream read data.

Function
REQ-019 FSM states: IDLE, SETUP, STROBE, HOLD, DONE, RECOVER; one 4-bit down-counter times SETUP/STROBE/HOLD/RECOVER.
REQ-020 All coe_* outputs and avs_waitrequest registered; no combinational path input->output.
REQ-021 IDLE: avs_waitrequest=1, coe_cs_n=1, strobes=1; on avs_read|avs_write sampled high, latch address, writedata, direction; go SETUP (or STROBE if T_SETUP=0).
REQ-022 avs_read and avs_write both high: treated as write.
REQ-023 SETUP: coe_cs_n=0, address valid, both strobes high, T_SETUP cycles.
REQ-024 STROBE: coe_cs_n=0, selected strobe low, T_STROBE cycles; coe_readdata captured into avs_readdata on the edge ending the last STROBE cycle.
REQ-025 HOLD: coe_cs_n=0, strobes high, address/writedata stable, T_HOLD cycles.
REQ-026 DONE: exactly 1 cycle, coe_cs_n=1, avs_waitrequest=0; avs_readdata held until next read capture.
REQ-027 RECOVER: coe_cs_n=1, avs_waitrequest=1, T_RECOVER cycles, then IDLE; requests ignored until IDLE.
REQ-028 Latency: DONE cycle occurs 1+T_SETUP+T_STROBE+T_HOLD cycles after the first IDLE cycle with request high (defaults: 7).
REQ-029 Minimum request-to-request period = 2+T_SETUP+T_STROBE+T_HOLD+T_RECOVER cycles (defaults: 10).
REQ-030 Request deasserted mid-access: access completes unchanged using latched values.
REQ-031 coe_address/coe_writedata change only in IDLE-exit edge; never during cs_n low.
REQ-032 coe_read_n and coe_write_n never low simultaneously; strobes never low while coe_cs_n high.

Reset
REQ-033 rsi_rst_n low asynchronously forces: state IDLE, counter 0, coe_cs_n=1, coe_read_n=1, coe_write_n=1, coe_address=0, coe_writedata=0, avs_readdata=0, avs_waitrequest=1.
REQ-034 Reset mid-access aborts the access; strobes release in the same cycle; no DONE issued.
REQ-035 After rsi_rst_n rises, first request accepted on the first rising edge.

Structure
REQ-036 Shared package isp1761_pkg holds state enum and default timing constants (T_SETUP/T_STROBE/T_HOLD/T_RECOVER defaults).
REQ-037 No sub-module; single module with FSM and counter.

Verification
REQ-038 Defaults, write 0xDEADBEEF to 0x00304: cs_n low 6 cycles, write_n low 4, coe_writedata=0xDEADBEEF throughout, waitrequest low exactly 1 cycle at cycle 7.
REQ-039 Defaults, read 0x0030C with coe_readdata=0x12345678 during strobe: avs_readdata=0x12345678 in DONE cycle, read_n low 4 cycles.
REQ-040 Back-to-back writes held high: second cs_n falling edge exactly 10 cycles after first.
REQ-041 T_SETUP=0,T_HOLD=0,T_RECOVER=0,T_STROBE=1: read completes with DONE 2 cycles after request; period 3.
REQ-042 rsi_rst_n pulsed low during STROBE: strobes/cs_n high immediately, waitrequest=1, no DONE; next request completes normally.
REQ-043 avs_read and avs_write high together: only coe_write_n pulses; assertion REQ-032 checked on all tests.
